// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Brief    : Shared types and constants for the 4x4 keypad scanner:
//             FSM state encoding, scan classification, key map and the
//             auto-repeat interval.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_EVAL   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } scan_cls_e;

    // Indexed by {row, col}; row 0 is the top row, col 0 the leftmost column.
    localparam logic [3:0] C_KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Scans between repeated key_valid pulses while a key stays held.
    localparam int unsigned C_REPEAT_SCANS = 8;

    // Number of pressed keys in a scan image.
    function automatic logic [4:0] f_count_keys(input logic [15:0] img);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, img[4'(i)]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Brief    : Column settle down-counter. A load restarts the count at
//             SETTLE_CYC-1; done is high once the count reaches zero, so a
//             state entered with load and left on done lasts SETTLE_CYC cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int SETTLE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam logic [15:0] C_RELOAD = 16'(SETTLE_CYC - 1);

    logic [15:0] r_cnt;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (load) begin
            r_cnt <= C_RELOAD;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign done = (r_cnt == 16'd0);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_ctrl
//  Brief    : 4x4 matrix keypad scanner. Drives one column low at a time,
//             samples the synchronised rows, classifies each full scan and
//             debounces presses/releases over DEBOUNCE_SCANS scans.
//             Optional macro KEYPAD_AUTO_REPEAT_EN: re-pulse key_valid every
//             8 scans while a key is held.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam logic [1:0] C_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] C_ST_DRIVE  = ST_DRIVE;
    localparam logic [1:0] C_ST_SAMPLE = ST_SAMPLE;
    localparam logic [1:0] C_ST_EVAL   = ST_EVAL;

    localparam logic [3:0] C_DB_MAX    = 4'(DEBOUNCE_SCANS);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_idx;
    logic [3:0]  r_row_s1;
    logic [3:0]  r_row_s2;
    logic [15:0] r_scan;
    logic [3:0]  w_col;

    logic        w_timer_load;
    logic        w_timer_done;

    logic [4:0]  w_nkeys;
    logic [3:0]  w_code;
    scan_cls_e   w_cls;
    scan_cls_e   r_prev_cls;
    logic [3:0]  r_prev_code;
    logic [3:0]  r_db_cnt;
    logic [3:0]  w_db_next;
    logic        w_match;
    logic        w_is_eval;
    logic        w_press;
    logic        w_release;

    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;
    logic        r_multi_key;

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam logic [2:0] C_REP_LAST = 3'(C_REPEAT_SCANS - 1);
    logic [2:0]  r_rep_cnt;
`endif

    // Settle timer for the driven column.
    scan_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_scan_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_timer_load),
        .done  (w_timer_done)
    );

    // Next-state decode; enable is only consulted at scan boundaries so a
    // started scan always runs through EVAL.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE:   if (enable) w_next_state = C_ST_DRIVE;
            C_ST_DRIVE:  if (w_timer_done) w_next_state = C_ST_SAMPLE;
            C_ST_SAMPLE: w_next_state = (r_idx == 2'd3) ? C_ST_EVAL : C_ST_DRIVE;
            C_ST_EVAL:   w_next_state = enable ? C_ST_DRIVE : C_ST_IDLE;
            default:     w_next_state = C_ST_IDLE;
        endcase
    end

    // Restart the settle count whenever a column drive begins.
    assign w_timer_load = (w_next_state == C_ST_DRIVE) && (r_state != C_ST_DRIVE);

    // State register and column index; the index wraps to 0 after column 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == C_ST_IDLE) begin
                r_idx <= 2'd0;
            end else if (r_state == C_ST_SAMPLE) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Active column stays low through its SAMPLE cycle; all high otherwise.
    always_comb begin
        w_col = 4'hF;
        if ((r_state == C_ST_DRIVE) || (r_state == C_ST_SAMPLE)) begin
            w_col[r_idx] = 1'b0;
        end
    end

    assign col = w_col;

    // Two-flop synchroniser for the asynchronous row inputs (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Capture the active column into the scan image; bit {row,col} = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= 16'd0;
        end else if (r_state == C_ST_SAMPLE) begin
            for (int r = 0; r < 4; r++) begin
                r_scan[{2'(r), r_idx}] <= ~r_row_s2[2'(r)];
            end
        end
    end

    // Classify the completed scan image.
    always_comb begin
        w_nkeys = f_count_keys(r_scan);
        w_code  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_scan[4'(i)]) begin
                w_code = C_KEY_MAP[4'(i)];
            end
        end
        if (w_nkeys == 5'd0) begin
            w_cls = CLS_NONE;
        end else if (w_nkeys == 5'd1) begin
            w_cls = CLS_SINGLE;
        end else begin
            w_cls = CLS_MULTI;
        end
    end

    // Debounce count update: a matching scan counts up (saturating), a
    // changed scan restarts at 1, and a multi-key scan clears the count.
    always_comb begin
        w_match = (w_cls == r_prev_cls) &&
                  ((w_cls != CLS_SINGLE) || (w_code == r_prev_code));
        if (w_cls == CLS_MULTI) begin
            w_db_next = 4'd0;
        end else if (!w_match) begin
            w_db_next = 4'd1;
        end else if (r_db_cnt >= C_DB_MAX) begin
            w_db_next = C_DB_MAX;
        end else begin
            w_db_next = r_db_cnt + 4'd1;
        end
    end

    assign w_is_eval = (r_state == C_ST_EVAL);
    assign w_press   = w_is_eval && (w_cls == CLS_SINGLE) &&
                       (w_db_next == C_DB_MAX) && !r_key_held;
    assign w_release = w_is_eval && (w_cls == CLS_NONE) &&
                       (w_db_next == C_DB_MAX) && r_key_held;

    // Debounce history, updated once per scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_cls  <= CLS_NONE;
            r_prev_code <= 4'h0;
            r_db_cnt    <= 4'd0;
            r_multi_key <= 1'b0;
        end else if (w_is_eval) begin
            r_prev_cls  <= w_cls;
            r_prev_code <= w_code;
            r_db_cnt    <= w_db_next;
            r_multi_key <= (w_cls == CLS_MULTI);
        end
    end

    // Accepted key, held flag and the one-cycle valid pulse after EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            r_rep_cnt   <= 3'd0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_press) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
`ifdef KEYPAD_AUTO_REPEAT_EN
                r_rep_cnt   <= 3'd0;
`endif
            end else if (w_release) begin
                r_key_held  <= 1'b0;
            end
`ifdef KEYPAD_AUTO_REPEAT_EN
            else if (w_is_eval && r_key_held) begin
                if (r_rep_cnt == C_REP_LAST) begin
                    r_key_valid <= 1'b1;
                    r_rep_cnt   <= 3'd0;
                end else begin
                    r_rep_cnt   <= r_rep_cnt + 3'd1;
                end
            end
`endif
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_key = r_multi_key;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan_ctrl
//  Brief    : Directed self-checking bench for keypad_scan_ctrl with
//             SETTLE_CYC=4, DEBOUNCE_SCANS=2 (21-cycle scan period). A
//             behavioural keypad pulls a row low when its key is pressed and
//             its column is driven low.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam logic [15:0] C_K1 = 16'h0001;
    localparam logic [15:0] C_KA = 16'h0008;
    localparam logic [15:0] C_K5 = 16'h0020;
    localparam logic [15:0] C_KB = 16'h0080;
    localparam logic [15:0] C_K7 = 16'h0100;
    localparam logic [15:0] C_K9 = 16'h0400;
    localparam logic [15:0] C_KD = 16'h8000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;

    logic [15:0] keys;
    int          n_checks;
    int          n_pass;
    int          pulse_cnt;

    keypad_scan_ctrl #(
        .SETTLE_CYC     (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: row r goes low if any pressed key in row r sits on a
    // column currently driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    // Count every cycle on which key_valid is high.
    always @(negedge clk) begin
        if (key_valid === 1'b1) pulse_cnt++;
    end

    // Wait for the EVAL cycle (col goes 0111 -> 1111), bounded.
    task automatic wait_eval(output int cyc);
        logic [3:0] pc;
        bit found;
        pc = col;
        found = 0;
        cyc = 0;
        while (!found && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (col == 4'hF && pc == 4'h7) found = 1;
            pc = col;
        end
        n_checks++;
        if (found) n_pass++;
        else $display("FAIL eval_timeout: no EVAL within %0d cycles, col=%h", cyc, col);
    endtask

    // Run to the end of one scan and sample outputs on the cycle after EVAL.
    task automatic do_scan(output logic kv, output logic held, output logic mk,
                           output logic [3:0] code);
        int c;
        wait_eval(c);
        @(negedge clk);
        #1;
        kv   = key_valid;
        held = key_held;
        mk   = multi_key;
        code = key_code;
    endtask

    task automatic test_reset();
        int c;
        rst_n = 1'b0;
        enable = 1'b0;
        keys = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (col !== 4'hF) $display("FAIL reset_col: got %h want f", col); else n_pass++;
        n_checks++; if (key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code); else n_pass++;
        n_checks++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid); else n_pass++;
        n_checks++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b want 0", key_held); else n_pass++;
        n_checks++; if (multi_key !== 1'b0) $display("FAIL reset_multi: got %b want 0", multi_key); else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (col !== 4'hF) $display("FAIL idle_col: got %h want f", col); else n_pass++;
        enable = 1'b1;
        @(negedge clk);
        n_checks++; if (col !== 4'hE) $display("FAIL start_col0: got %h want e", col); else n_pass++;
        wait_eval(c);
        n_checks++; if (c !== 20) $display("FAIL first_eval: got %0d want 20 cycles", c); else n_pass++;
        wait_eval(c);
        n_checks++; if (c !== 21) $display("FAIL scan_period: got %0d want 21 cycles", c); else n_pass++;
    endtask

    task automatic test_press();
        logic kv, hd, mk;
        logic [3:0] cd;
        int p0;
        p0 = pulse_cnt;
        keys = C_K5;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b0) $display("FAIL press_s1_valid: got %b want 0", kv); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b1) $display("FAIL press_s2_valid: got %b want 1", kv); else n_pass++;
        n_checks++; if (cd !== 4'h5) $display("FAIL press_s2_code: got %h want 5", cd); else n_pass++;
        n_checks++; if (hd !== 1'b1) $display("FAIL press_s2_held: got %b want 1", hd); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b0) $display("FAIL press_s3_valid: got %b want 0", kv); else n_pass++;
        n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL press_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
    endtask

    task automatic test_release();
        logic kv, hd, mk;
        logic [3:0] cd;
        int p0;
        p0 = pulse_cnt;
        keys = 16'h0;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (hd !== 1'b1) $display("FAIL release_s1_held: got %b want 1", hd); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (hd !== 1'b0) $display("FAIL release_s2_held: got %b want 0", hd); else n_pass++;
        n_checks++; if (pulse_cnt - p0 !== 0) $display("FAIL release_pulses: got %0d want 0", pulse_cnt - p0); else n_pass++;
    endtask

    task automatic test_multi();
        logic kv, hd, mk;
        logic [3:0] cd;
        int p0;
        p0 = pulse_cnt;
        keys = C_K1 | C_K9;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (mk !== 1'b1) $display("FAIL multi_s1_flag: got %b want 1", mk); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (mk !== 1'b1) $display("FAIL multi_s2_flag: got %b want 1", mk); else n_pass++;
        n_checks++; if (pulse_cnt - p0 !== 0) $display("FAIL multi_pulses: got %0d want 0", pulse_cnt - p0); else n_pass++;
        keys = C_K1;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (mk !== 1'b0) $display("FAIL multi_s3_flag: got %b want 0", mk); else n_pass++;
        n_checks++; if (kv !== 1'b0) $display("FAIL multi_s3_valid: got %b want 0", kv); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b1) $display("FAIL multi_s4_valid: got %b want 1", kv); else n_pass++;
        n_checks++; if (cd !== 4'h1) $display("FAIL multi_s4_code: got %h want 1", cd); else n_pass++;
        keys = 16'h0;
        do_scan(kv, hd, mk, cd);
        do_scan(kv, hd, mk, cd);
        n_checks++; if (hd !== 1'b0) $display("FAIL multi_rel_held: got %b want 0", hd); else n_pass++;
    endtask

    task automatic test_bounce();
        logic kv, hd, mk;
        logic [3:0] cd;
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? C_KD : 16'h0;
            do_scan(kv, hd, mk, cd);
        end
        n_checks++; if (pulse_cnt - p0 !== 0) $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - p0); else n_pass++;
        n_checks++; if (hd !== 1'b0) $display("FAIL bounce_held: got %b want 0", hd); else n_pass++;
    endtask

    task automatic test_enable_drop();
        logic kv, hd, mk;
        logic [3:0] cd;
        int c;
        bit stayed_idle;
        keys = C_KB;
        do_scan(kv, hd, mk, cd);
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b1 || cd !== 4'hB) $display("FAIL drop_accept: got valid=%b code=%h want 1/b", kv, cd); else n_pass++;
        repeat (6) @(negedge clk);
        enable = 1'b0;
        wait_eval(c);
        stayed_idle = 1;
        repeat (30) begin
            @(negedge clk);
            if (col !== 4'hF) stayed_idle = 0;
        end
        n_checks++; if (!stayed_idle) $display("FAIL drop_idle: col left 1111 while disabled, col=%h", col); else n_pass++;
        n_checks++; if (key_held !== 1'b1) $display("FAIL drop_held: got %b want 1", key_held); else n_pass++;
        n_checks++; if (key_code !== 4'hB) $display("FAIL drop_code: got %h want b", key_code); else n_pass++;
        enable = 1'b1;
        keys = 16'h0;
        do_scan(kv, hd, mk, cd);
        do_scan(kv, hd, mk, cd);
        n_checks++; if (hd !== 1'b0) $display("FAIL drop_release: got %b want 0", hd); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        logic kv, hd, mk;
        logic [3:0] cd;
        int p0, n;
        p0 = pulse_cnt;
        keys = C_K7;
        do_scan(kv, hd, mk, cd);
        n = 0;
        while (col !== 4'hD && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (col !== 4'hF) $display("FAIL rstmid_col: got %h want f", col); else n_pass++;
        n_checks++; if (key_code !== 4'h0) $display("FAIL rstmid_code: got %h want 0", key_code); else n_pass++;
        n_checks++; if (key_valid !== 1'b0 || key_held !== 1'b0 || multi_key !== 1'b0)
            $display("FAIL rstmid_flags: got valid=%b held=%b multi=%b want 0/0/0", key_valid, key_held, multi_key);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b0) $display("FAIL rstmid_s1_valid: got %b want 0", kv); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (kv !== 1'b1 || cd !== 4'h7) $display("FAIL rstmid_s2: got valid=%b code=%h want 1/7", kv, cd); else n_pass++;
        do_scan(kv, hd, mk, cd);
        n_checks++; if (pulse_cnt - p0 !== 1) $display("FAIL rstmid_pulses: got %0d want 1", pulse_cnt - p0); else n_pass++;
        keys = 16'h0;
        do_scan(kv, hd, mk, cd);
        do_scan(kv, hd, mk, cd);
    endtask

    task automatic test_auto_repeat();
        logic kv, hd, mk;
        logic [3:0] cd;
        logic exp;
        int p0, exp_pulses;
        p0 = pulse_cnt;
        keys = C_KA;
        for (int s = 1; s <= 20; s++) begin
            do_scan(kv, hd, mk, cd);
`ifdef KEYPAD_AUTO_REPEAT_EN
            exp = (s == 2 || s == 10 || s == 18);
`else
            exp = (s == 2);
`endif
            n_checks++;
            if (kv !== exp || (exp && cd !== 4'hA))
                $display("FAIL repeat_scan%0d: got valid=%b code=%h want valid=%b code=a", s, kv, cd, exp);
            else n_pass++;
        end
`ifdef KEYPAD_AUTO_REPEAT_EN
        exp_pulses = 3;
`else
        exp_pulses = 1;
`endif
        n_checks++; if (pulse_cnt - p0 !== exp_pulses) $display("FAIL repeat_pulses: got %0d want %0d", pulse_cnt - p0, exp_pulses); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        pulse_cnt = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        keys = 16'h0;
        test_reset();
        test_press();
        test_release();
        test_multi();
        test_bounce();
        test_enable_drop();
        test_reset_mid_scan();
        test_auto_repeat();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1000, meaning clock cycles each column is driven before its rows are sampled; legal range 1..65535.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full scans required to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: scanning runs while high.
REQ-006 SHALL have port row, input, 4 bits: keypad rows, active-low with external pull-ups.
REQ-007 SHALL have port col, output, 4 bits: keypad columns; exactly one column is driven low while scanning.
REQ-008 SHALL have port key_code, output, 4 bits: hex value of the last accepted key.
REQ-009 SHALL have port key_valid, output, 1 bit: single-cycle pulse when a key is accepted.
REQ-010 SHALL have port key_held, output, 1 bit: high from acceptance until the release is accepted.
REQ-011 SHALL have port multi_key, output, 1 bit: high while the most recent scan saw two or more keys.

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, SAMPLE and EVAL.
REQ-013 IDLE: col=4'b1111; the FSM leaves for DRIVE with column index 0 on the cycle after enable is seen high.
REQ-014 DRIVE: col[idx]=0 and the other columns are 1 for exactly SETTLE_CYC cycles, then the FSM goes to SAMPLE.
REQ-015 SAMPLE: one cycle; rows are captured into a 16-bit scan image and idx increments; idx 3 goes to EVAL, otherwise the FSM returns to DRIVE.
REQ-016 EVAL: one cycle; the scan is classified as NONE, SINGLE(code) or MULTI; the FSM returns to DRIVE with idx 0, or to IDLE if enable is low.
REQ-017 The scan period SHALL be 4*(SETTLE_CYC+1)+1 cycles.
REQ-018 Key map: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D, with columns 0..3 left to right.
REQ-019 Debounce counter: increments on a scan that matches the previous scan's classification and resets to 1 on a mismatch; it saturates at DEBOUNCE_SCANS.
REQ-020 Press acceptance: when SINGLE(code) reaches DEBOUNCE_SCANS while not held, the block SHALL register key_code=code and key_held=1, and pulse key_valid=1 on the cycle after EVAL.
REQ-021 Release acceptance: NONE reaching DEBOUNCE_SCANS while held SHALL clear key_held; no pulse is generated.
REQ-022 A different SINGLE code while held SHALL NOT generate a pulse until a release has been accepted.
REQ-023 MULTI SHALL never produce key_valid; it resets the debounce counter and sets multi_key until the next EVAL.
REQ-024 enable dropping mid-scan SHALL let the current scan finish through EVAL, then go to IDLE with held state kept.
REQ-025 An asynchronous row change during DRIVE SHALL be tolerated; only the SAMPLE-cycle value is used, taken through a 2-flop synchronizer.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, col=4'b1111, key_code=0, key_valid=0, key_held=0, multi_key=0, and all counters and the scan image cleared.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no pulse; after release the block restarts from IDLE.

Configuration
REQ-028 With macro KEYPAD_AUTO_REPEAT_EN defined, while key_held=1 the block SHALL re-pulse key_valid with the same code every 8 scans after the initial acceptance.
REQ-029 Without KEYPAD_AUTO_REPEAT_EN, exactly one pulse SHALL occur per accepted press.

Structure
REQ-030 Package keypad_pkg SHALL hold the FSM state enum, the scan classification enum, the 16-entry key-map constant array and the auto-repeat interval constant (8).
REQ-031 Sub-module scan_timer SHALL implement the SETTLE_CYC down-counter with load and done outputs; the FSM, debounce and output logic live in keypad_scan_ctrl.

Verification
REQ-032 The bench SHALL use SETTLE_CYC=4 and DEBOUNCE_SCANS=2, giving a 21-cycle period, and cover these scenarios:
REQ-033 Hold key 5 (row1 low while col1 is low) for 3 scans -> exactly one key_valid with key_code=4'h5, within the EVAL+1 cycle of the 2nd scan.
REQ-034 Release after acceptance for 2 scans -> key_held falls after the 2nd empty EVAL; no key_valid.
REQ-035 Press 1 and 9 simultaneously -> multi_key=1, no key_valid; release 9 keeping 1 for 2 scans -> key_valid with code 4'h1.
REQ-036 Bounce key D (alternating pressed/empty on each scan) for 6 scans -> no key_valid.
REQ-037 rst_n low mid-DRIVE of scan 2 of key 7 -> col=4'hF immediately, all outputs 0, no pulse; after 3 scans held -> one pulse, code 4'h7.
REQ-038 With KEYPAD_AUTO_REPEAT_EN, hold key A for 20 scans -> pulses after scans 2, 10 and 18, each with code 4'hA.
